// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and a
// constant-evaluable ceiling log2 used to size the iteration counter.
package mul_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_rca.sv
// N-bit ripple-carry adder: a chain of full adders.
// Serves as the accumulate stage of the shift-add multiplier.
module rca_add_n #(
    parameter int N = 64
) (
    output logic [N-1:0] sum,
    output logic         cout,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin
);

    logic [N:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign cout = w_c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with start/busy/done handshake.
// Optional early exit when the remaining multiplier is zero: SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    import mul_pkg::*;

    localparam int CNT_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_sum;
    logic               w_cout_unused;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic               w_last;

    rca_add_n #(.N(2*WIDTH)) u_add (
        .sum  (w_sum),
        .cout (w_cout_unused),
        .x    (r_acc),
        .y    (r_mcand),
        .cin  (1'b0)
    );

    assign w_acc_nxt    = r_mplier[0] ? w_sum : r_acc;
    assign w_mplier_nxt = r_mplier >> 1;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    // No remaining multiplier bits means no further adds can change acc.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_nxt == '0);
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed check of shift_add_multiplier against an arithmetic
// reference (a*b, latency from the multiplier's bit length in early-exit builds).
module tb_shift_add_multiplier;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int total = 0;
    int bad   = 0;
    logic [2*WIDTH-1:0] last_prod;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_lat(input logic [WIDTH-1:0] bv);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        int n;
        logic [WIDTH-1:0] x;
        n = 0;
        x = bv;
        while (x != 0) begin
            n++;
            x = x >> 1;
        end
        return (n == 0) ? 1 : n;
`else
        return WIDTH;
`endif
    endfunction

    // One multiply: start at edge T, then count edges until done is seen.
    // repulse > 0 drives a fresh start (a=3,b=3) so it is sampled at edge T+repulse+1.
    task automatic mul_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int repulse);
        int n;
        bit seen;
        bit busy_ok;
        logic [2*WIDTH-1:0] exp;
        n       = 0;
        seen    = 0;
        busy_ok = 1;
        exp     = 64'(av) * 64'(bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!busy) busy_ok = 0;
        check_val("prod_hold_after_start", product, last_prod);
        for (int i = 0; i < WIDTH + 4 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_ok = 0;
            if (done) seen = 1;
            else if (n == repulse) begin
                start = 1'b1;
                a = 3;
                b = 3;
            end else start = 1'b0;
        end
        start = 1'b0;
        check_val("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_val("latency", 64'(n), 64'(ref_lat(bv)));
            check_val("product", product, exp);
            check_val("busy_during_op", 64'(busy_ok), 64'd1);
            @(posedge clk);
            #1;
            check_val("done_pulse_busy_clear", {62'd0, done, busy}, 64'd0);
            check_val("product_held", product, exp);
        end
        last_prod = exp;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        bit seen;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        int rst_n;
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #2 rst = 1'b1;
        #1;
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_product", product, 64'd0);
        last_prod = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        mul_op(32'd0, 32'd0, 0);
        mul_op(32'd1, 32'd2, 0);
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_val("max_operands", product, 64'hFFFF_FFFE_0000_0001);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        mul_op(32'd7, 32'd6, 1);
        rst_n = 2;
`else
        mul_op(32'd7, 32'd6, 4);
        rst_n = 9;
`endif
        check_val("ignored_restart", product, 64'd42);

        // Abort mid-run with asynchronous reset
        a = 9;
        b = 9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (rst_n) begin
            @(posedge clk);
            #1;
        end
        check_val("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_product", product, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check_val("no_done_after_abort", 64'(seen), 64'd0);
        last_prod = '0;

        mul_op(32'd5, 32'd1, 0);

        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i % 4 == 0) bv = bv >> $urandom_range(31, 0);
            if (i % 50 == 0) bv = 32'(i % 2);
            mul_op(av, bv, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
